// File: rtl/pci_arbiter_pkg.sv
// Shared definitions for the PCI arbiter family: master count, index width,
// FSM encodings and the index-to-GNT# helper.
package pci_arbiter_pkg;

    localparam int unsigned NUM_MASTERS = 8;
    localparam int unsigned IDX_W       = 3;

    typedef logic [IDX_W-1:0]       idx_t;
    typedef logic [NUM_MASTERS-1:0] vec_t;

    // FSM encodings kept as plain constants so older arbiters can share them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // All GNT# lines deasserted
    localparam vec_t GNT_NONE = 8'hFF;

    // Active-low one-hot GNT# pattern for a master index
    function automatic vec_t idx_to_gnt_n(input idx_t idx);
        vec_t v;
        v      = GNT_NONE;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting master at or after ptr.
module pci_rr_pick
    import pci_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_n,
    input  logic [IDX_W-1:0]       ptr,
    output logic [IDX_W-1:0]       win_idx,
    output logic                   win_valid
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from the far end so the closest requester to ptr is kept last
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (!req_n[cand]) begin
                win_idx   = cand;
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter for 8 masters: round-robin grants, optional parking and a
// start timeout that reclaims GNT# from masters that never start a transaction.
module pci_arbiter
    import pci_arbiter_pkg::*;
#(
    parameter int unsigned GNT_TIMEOUT = 16,
    parameter bit          PARK_EN     = 1'b1,
    parameter int unsigned PARK_MASTER = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_n,
    input  logic                   frame_n,
    input  logic                   irdy_n,
    output logic [NUM_MASTERS-1:0] gnt_n,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   gnt_valid,
    output logic                   parked
);

    localparam idx_t       PARK_IDX   = idx_t'(PARK_MASTER);
    localparam logic [7:0] TIMEOUT_M1 = 8'(GNT_TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic                   gnt_valid_q, gnt_valid_d;
    logic                   parked_q, parked_d;
    logic                   bus_idle_q;

    logic                   bus_idle;
    logic                   other_req;
    logic                   own_req;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;

    assign bus_idle  = frame_n & irdy_n;
    // gnt_n_q has a 1 everywhere except the owner, so this masks the owner out
    assign other_req = |(~req_n & gnt_n_q);
    assign own_req   = ~req_n[gnt_idx_q];

    pci_rr_pick u_pick (
        .req_n     (req_n),
        .ptr       (ptr_q),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // Next-state and next-output computation for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_n_d     = gnt_n_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        parked_d    = parked_q;

        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (win_valid) begin
                    state_d     = ST_GRANT;
                    gnt_n_d     = idx_to_gnt_n(win_idx);
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    parked_d    = 1'b0;
                    cnt_d       = '0;
                end else if (PARK_EN) begin
                    state_d     = ST_GRANT;
                    gnt_n_d     = idx_to_gnt_n(PARK_IDX);
                    gnt_idx_d   = PARK_IDX;
                    gnt_valid_d = 1'b1;
                    parked_d    = 1'b1;
                    cnt_d       = '0;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_n_d     = GNT_NONE;
                    gnt_valid_d = 1'b0;
                    parked_d    = 1'b0;
                end
            end

            ST_GRANT: begin
                if (bus_idle_q && !frame_n) begin
                    // Owner started a transaction: move the pointer past it
                    state_d     = ST_TURN;
                    gnt_n_d     = GNT_NONE;
                    gnt_valid_d = 1'b0;
                    parked_d    = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                end else if (parked_q && other_req) begin
                    state_d     = ST_TURN;
                    gnt_n_d     = GNT_NONE;
                    gnt_valid_d = 1'b0;
                    parked_d    = 1'b0;
                end else if (!parked_q && !own_req) begin
                    // Request withdrawn before start
                    state_d     = ST_TURN;
                    gnt_n_d     = GNT_NONE;
                    gnt_valid_d = 1'b0;
                    parked_d    = 1'b0;
                end else if (!parked_q && (cnt_q == TIMEOUT_M1) && bus_idle) begin
                    // Start timeout: owner loses its turn
                    state_d     = ST_TURN;
                    gnt_n_d     = GNT_NONE;
                    gnt_valid_d = 1'b0;
                    parked_d    = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                end else if (parked_q && own_req) begin
                    // Park grant becomes a real grant; timeout starts fresh
                    parked_d = 1'b0;
                    cnt_d    = '0;
                end else if (bus_idle) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_n_d     = GNT_NONE;
                gnt_valid_d = 1'b0;
                parked_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops GNT# immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_n_q     <= GNT_NONE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            parked_q    <= 1'b0;
            bus_idle_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_n_q     <= gnt_n_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            parked_q    <= parked_d;
            bus_idle_q  <= bus_idle;
        end
    end

    assign gnt_n     = gnt_n_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign parked    = parked_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed testbench for pci_arbiter.
module tb_pci_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       parked;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [7:0] prev_gnt = 8'hFF;

    always #5 clk = ~clk;

    pci_arbiter #(
        .GNT_TIMEOUT (16),
        .PARK_EN     (1'b1),
        .PARK_MASTER (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_n     (req_n),
        .frame_n   (frame_n),
        .irdy_n    (irdy_n),
        .gnt_n     (gnt_n),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .parked    (parked)
    );

    // Per-cycle invariants: one-hot-or-none GNT#, flags consistent, no GNT#-to-GNT# handoff
    always @(negedge clk) begin
        if (rst) begin
            prev_gnt = 8'hFF;
        end else begin
            n_vec++;
            if ($countones(~gnt_n) > 1) begin
                n_bad++;
                $display("FAIL onehot gnt_n: got %h required at most one zero", gnt_n);
            end
            n_vec++;
            if (gnt_valid !== (gnt_n != 8'hFF)) begin
                n_bad++;
                $display("FAIL valid_consistent: gnt_valid %b with gnt_n %h", gnt_valid, gnt_n);
            end
            n_vec++;
            if (prev_gnt != 8'hFF && gnt_n != 8'hFF && gnt_n != prev_gnt) begin
                n_bad++;
                $display("FAIL back_to_back: gnt_n %h directly after %h", gnt_n, prev_gnt);
            end
            prev_gnt = gnt_n;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves rst asserted with idle inputs, 1ns after a clock edge
    task automatic do_reset();
        rst     = 1'b1;
        req_n   = 8'hFF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL reset gnt_n: got %h want ff", gnt_n); end
        n_vec++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL reset gnt_valid: got %b want 0", gnt_valid); end
        n_vec++; if (gnt_idx !== 3'd0) begin n_bad++; $display("FAIL reset gnt_idx: got %0d want 0", gnt_idx); end
        n_vec++; if (parked !== 1'b0) begin n_bad++; $display("FAIL reset parked: got %b want 0", parked); end
        rst = 1'b0;
        step(1);
        n_vec++; if (gnt_n !== 8'hFE) begin n_bad++; $display("FAIL park gnt_n: got %h want fe", gnt_n); end
        n_vec++; if (parked !== 1'b1) begin n_bad++; $display("FAIL park parked: got %b want 1", parked); end
        n_vec++; if (gnt_idx !== 3'd0) begin n_bad++; $display("FAIL park gnt_idx: got %0d want 0", gnt_idx); end
        n_vec++; if (gnt_valid !== 1'b1) begin n_bad++; $display("FAIL park gnt_valid: got %b want 1", gnt_valid); end
    endtask

    task automatic test_park_handoff();
        req_n = 8'hF7;
        step(1);
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL handoff turn: got %h want ff", gnt_n); end
        step(1);
        n_vec++; if (gnt_n !== 8'hF7) begin n_bad++; $display("FAIL handoff grant3: got %h want f7", gnt_n); end
        n_vec++; if (parked !== 1'b0) begin n_bad++; $display("FAIL handoff parked: got %b want 0", parked); end
        frame_n = 1'b0;
        step(1);
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL handoff start: got %h want ff", gnt_n); end
        frame_n = 1'b1;
        req_n   = 8'h00;
        step(1);
        n_vec++; if (gnt_n !== 8'hEF) begin n_bad++; $display("FAIL handoff ptr4: got %h want ef", gnt_n); end
        n_vec++; if (gnt_idx !== 3'd4) begin n_bad++; $display("FAIL handoff ptr4 idx: got %0d want 4", gnt_idx); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g;
        do_reset();
        req_n = 8'h00;
        rst   = 1'b0;
        step(1);
        for (int i = 0; i < 9; i++) begin
            exp_g = ~(8'h01 << (i % 8));
            n_vec++; if (gnt_n !== exp_g) begin n_bad++; $display("FAIL rr grant %0d: got %h want %h", i, gnt_n, exp_g); end
            n_vec++; if (gnt_idx !== 3'(i % 8)) begin n_bad++; $display("FAIL rr idx %0d: got %0d want %0d", i, gnt_idx, i % 8); end
            frame_n = 1'b0;
            step(1);
            frame_n = 1'b1;
            n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL rr turn %0d: got %h want ff", i, gnt_n); end
            step(1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_n = 8'hFB;
        rst   = 1'b0;
        step(1);
        for (int k = 0; k < 16; k++) begin
            n_vec++; if (gnt_n !== 8'hFB) begin n_bad++; $display("FAIL timeout hold %0d: got %h want fb", k, gnt_n); end
            step(1);
        end
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL timeout revoke: got %h want ff", gnt_n); end
        step(1);
        n_vec++; if (gnt_n !== 8'hFB) begin n_bad++; $display("FAIL timeout regrant: got %h want fb", gnt_n); end
    endtask

    task automatic test_hidden_busy();
        do_reset();
        frame_n = 1'b0;
        irdy_n  = 1'b0;
        req_n   = 8'hBF;
        rst     = 1'b0;
        step(20);
        n_vec++; if (gnt_n !== 8'hBF) begin n_bad++; $display("FAIL busy hold: got %h want bf", gnt_n); end
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        step(1);
        frame_n = 1'b0;
        step(1);
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL busy start: got %h want ff", gnt_n); end
        frame_n = 1'b1;
    endtask

    task automatic test_withdraw();
        do_reset();
        req_n = 8'hDF;
        rst   = 1'b0;
        step(1);
        n_vec++; if (gnt_n !== 8'hDF) begin n_bad++; $display("FAIL withdraw grant5: got %h want df", gnt_n); end
        req_n = 8'hFF;
        step(1);
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL withdraw turn: got %h want ff", gnt_n); end
        step(1);
        n_vec++; if (gnt_n !== 8'hFE) begin n_bad++; $display("FAIL withdraw park: got %h want fe", gnt_n); end
        n_vec++; if (parked !== 1'b1) begin n_bad++; $display("FAIL withdraw parked: got %b want 1", parked); end
        req_n = 8'hFE;
        step(1);
        n_vec++; if (gnt_n !== 8'hFE) begin n_bad++; $display("FAIL own_req gnt_n: got %h want fe", gnt_n); end
        n_vec++; if (parked !== 1'b0) begin n_bad++; $display("FAIL own_req parked: got %b want 0", parked); end
        req_n = 8'hFF;
        step(1);
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL own_req drop: got %h want ff", gnt_n); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_n = 8'hEF;
        rst   = 1'b0;
        step(1);
        frame_n = 1'b0;
        step(1);
        frame_n = 1'b1;
        step(1);
        n_vec++; if (gnt_n !== 8'hEF) begin n_bad++; $display("FAIL areset pre: got %h want ef", gnt_n); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (gnt_n !== 8'hFF) begin n_bad++; $display("FAIL areset gnt_n: got %h want ff", gnt_n); end
        n_vec++; if (gnt_valid !== 1'b0) begin n_bad++; $display("FAIL areset gnt_valid: got %b want 0", gnt_valid); end
        rst   = 1'b0;
        req_n = 8'h00;
        @(posedge clk);
        #1;
        n_vec++; if (gnt_n !== 8'hFE) begin n_bad++; $display("FAIL areset restart: got %h want fe", gnt_n); end
        n_vec++; if (gnt_idx !== 3'd0) begin n_bad++; $display("FAIL areset restart idx: got %0d want 0", gnt_idx); end
    endtask

    initial begin
        rst     = 1'b1;
        req_n   = 8'hFF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        test_reset();
        test_park_handoff();
        test_round_robin();
        test_timeout();
        test_hidden_busy();
        test_withdraw();
        test_async_reset();
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
